// File: rtl/cpu_riscv.sv
// cpu_riscv: single-cycle RV32I-subset core with instruction ROM, data RAM,
// 32x32 register file and an 8-digit multiplexed seven-segment driver.
// Program output reaches the display through ecall (a7=34 prints a0).
// Optional build macro CPU_RISCV_INSTCNT_EN adds a retired-instruction
// counter that ecall a7=36 copies to the display.
module cpu_riscv #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter string       IMEM_FILE  = "prog.hex",
  parameter int unsigned SCAN_DIV   = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Go,
  output logic [7:0]  SEG,
  output logic [7:0]  AN,
  output logic        halt,
  output logic [31:0] PC_Data,
  output logic [31:0] IR_Data,
  output logic [31:0] in_PC,
  output logic [31:0] LED_num,
  output logic [4:0]  R1Addr,
  output logic [4:0]  R2Addr,
  output logic [4:0]  RD,
  output logic [31:0] R1Data,
  output logic [31:0] R2Data,
  output logic [31:0] ALUData,
  output logic [31:0] rd_in,
  output logic [31:0] Imm_value,
  output logic [31:0] Imm_shift_value,
  output logic        e_signal
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);
  localparam int unsigned SCW = SCAN_DIV + 3;

  typedef enum logic [0:0] {S_RUN, S_HALT} state_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  logic [31:0]    imem [IMEM_WORDS];
  logic [31:0]    dmem [DMEM_WORDS];
  logic [31:0]    rf   [32];
  logic [31:0]    pc;
  logic [31:0]    led;
  logic [SCW-1:0] scan_cnt;
  state_t         state, state_next;
  logic           run;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7b5;
  logic        is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic [31:0] alu_a, alu_b, mem_rdata, a7, a0;
  alu_op_t     alu_op;
  logic        br_taken, reg_we;
  logic        ecall_print, ecall_cnt, ecall_stop;
  logic [2:0]  digit;
  logic [3:0]  nibble;

  assign PC_Data         = pc;
  assign LED_num         = led;
  assign IR_Data         = imem[pc[IAW+1:2]];
  assign opcode          = IR_Data[6:0];
  assign f3              = IR_Data[14:12];
  assign f7b5            = IR_Data[30];
  assign R1Addr          = IR_Data[19:15];
  assign R2Addr          = IR_Data[24:20];
  assign RD              = IR_Data[11:7];
  assign R1Data          = (R1Addr == 5'd0) ? '0 : rf[R1Addr];
  assign R2Data          = (R2Addr == 5'd0) ? '0 : rf[R2Addr];
  assign a7              = rf[17];
  assign a0              = rf[10];
  assign e_signal        = (IR_Data == 32'h0000_0073);
  assign Imm_shift_value = Imm_value << 1;
  assign mem_rdata       = dmem[ALUData[DAW+1:2]];

  // Instruction class decode; non-word loads/stores fall through as nops.
  always_comb begin
    is_r     = (opcode == 7'b0110011);
    is_i     = (opcode == 7'b0010011);
    is_ld    = (opcode == 7'b0000011) && (f3 == 3'b010);
    is_st    = (opcode == 7'b0100011) && (f3 == 3'b010);
    is_br    = (opcode == 7'b1100011);
    is_jal   = (opcode == 7'b1101111);
    is_jalr  = (opcode == 7'b1100111);
    is_lui   = (opcode == 7'b0110111);
    is_auipc = (opcode == 7'b0010111);
  end

  // Immediate generation; B/J carry offset>>1 so Imm_shift_value is the byte offset.
  always_comb begin
    Imm_value = '0;
    if (is_i || is_ld || is_jalr)
      Imm_value = {{20{IR_Data[31]}}, IR_Data[31:20]};
    else if (is_st)
      Imm_value = {{20{IR_Data[31]}}, IR_Data[31:25], IR_Data[11:7]};
    else if (is_lui || is_auipc)
      Imm_value = {IR_Data[31:12], 12'b0};
    else if (is_br)
      Imm_value = {{20{IR_Data[31]}}, IR_Data[31], IR_Data[7], IR_Data[30:25], IR_Data[11:8]};
    else if (is_jal)
      Imm_value = {{12{IR_Data[31]}}, IR_Data[31], IR_Data[19:12], IR_Data[20], IR_Data[30:21]};
  end

  // ALU operand and operation select.
  always_comb begin
    alu_a  = is_auipc ? pc : R1Data;
    alu_b  = (is_r || is_br) ? R2Data : Imm_value;
    alu_op = ALU_ADD;
    if (is_lui) begin
      alu_op = ALU_PASSB;
    end else if (is_br) begin
      alu_op = ALU_SUB;
    end else if (is_r || is_i) begin
      unique case (f3)
        3'b000:  alu_op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

  // ALU datapath.
  always_comb begin
    unique case (alu_op)
      ALU_SUB:   ALUData = alu_a - alu_b;
      ALU_SLL:   ALUData = alu_a << alu_b[4:0];
      ALU_SLT:   ALUData = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  ALUData = {31'b0, alu_a < alu_b};
      ALU_XOR:   ALUData = alu_a ^ alu_b;
      ALU_SRL:   ALUData = alu_a >> alu_b[4:0];
      ALU_SRA:   ALUData = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_OR:    ALUData = alu_a | alu_b;
      ALU_AND:   ALUData = alu_a & alu_b;
      ALU_PASSB: ALUData = alu_b;
      default:   ALUData = alu_a + alu_b;
    endcase
  end

  // Branch condition evaluation.
  always_comb begin
    unique case (f3)
      3'b000:  br_taken = (R1Data == R2Data);
      3'b001:  br_taken = (R1Data != R2Data);
      3'b100:  br_taken = ($signed(R1Data) <  $signed(R2Data));
      3'b101:  br_taken = ($signed(R1Data) >= $signed(R2Data));
      3'b110:  br_taken = (R1Data <  R2Data);
      3'b111:  br_taken = (R1Data >= R2Data);
      default: br_taken = 1'b0;
    endcase
    br_taken = br_taken && is_br;
  end

  // Write-back source and register-file write enable.
  always_comb begin
    if (is_ld)                  rd_in = mem_rdata;
    else if (is_jal || is_jalr) rd_in = pc + 32'd4;
    else                        rd_in = ALUData;
    reg_we = run && (RD != 5'd0) &&
             (is_r || is_i || is_ld || is_jal || is_jalr || is_lui || is_auipc);
  end

  assign ecall_print = e_signal && (a7 == 32'd34);
`ifdef CPU_RISCV_INSTCNT_EN
  logic [31:0] inst_cnt;
  assign ecall_cnt = e_signal && (a7 == 32'd36);
`else
  assign ecall_cnt = 1'b0;
`endif
  assign ecall_stop = e_signal && !ecall_print && !ecall_cnt;

  // Next-PC selection; a halting ecall and the halted state both hold PC.
  always_comb begin
    if (!run || ecall_stop)      in_PC = pc;
    else if (is_jalr)            in_PC = (R1Data + Imm_value) & ~32'd1;
    else if (is_jal || br_taken) in_PC = pc + Imm_shift_value;
    else                         in_PC = pc + 32'd4;
  end

  // Run/halt state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_RUN;
    else     state <= state_next;
  end

  // Run/halt next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      S_RUN:   if (ecall_stop) state_next = S_HALT;
      S_HALT:  if (Go)         state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  // Run/halt outputs.
  always_comb begin
    halt = (state == S_HALT);
    run  = (state == S_RUN);
  end

  // Architectural state: PC, register file and display register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc  <= '0;
      led <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (run) begin
      pc <= in_PC;
      if (reg_we)      rf[RD] <= rd_in;
      if (ecall_print) led    <= a0;
`ifdef CPU_RISCV_INSTCNT_EN
      if (ecall_cnt)   led    <= inst_cnt;
`endif
    end else if (Go) begin
      pc <= pc + 32'd4;
    end
  end

`ifdef CPU_RISCV_INSTCNT_EN
  // Retired-instruction counter; a halting ecall does not retire until resumed.
  always_ff @(posedge CLK) begin
    if (RST)                     inst_cnt <= '0;
    else if (run && !ecall_stop) inst_cnt <= inst_cnt + 32'd1;
  end
`endif

  // Data RAM word store; contents survive reset.
  always_ff @(posedge CLK) begin
    if (!RST && run && is_st) dmem[ALUData[DAW+1:2]] <= R2Data;
  end

  // Display scan prescaler; top three bits select the digit.
  always_ff @(posedge CLK) begin
    if (RST) scan_cnt <= '0;
    else     scan_cnt <= scan_cnt + 1'b1;
  end

  assign digit  = scan_cnt[SCW-1 -: 3];
  assign AN     = ~(8'h01 << digit);
  assign nibble = led[{digit, 2'b00} +: 4];

  // Hex nibble to active-low segments, dp held off.
  always_comb begin
    unique case (nibble)
      4'h0: SEG = 8'hC0;  4'h1: SEG = 8'hF9;  4'h2: SEG = 8'hA4;  4'h3: SEG = 8'hB0;
      4'h4: SEG = 8'h99;  4'h5: SEG = 8'h92;  4'h6: SEG = 8'h82;  4'h7: SEG = 8'hF8;
      4'h8: SEG = 8'h80;  4'h9: SEG = 8'h90;  4'hA: SEG = 8'h88;  4'hB: SEG = 8'h83;
      4'hC: SEG = 8'hC6;  4'hD: SEG = 8'hA1;  4'hE: SEG = 8'h86;  default: SEG = 8'h8E;
    endcase
  end

endmodule

// File: tb/tb_cpu_riscv.sv
// tb_cpu_riscv: directed programs written into the DUT ROM, with
// hand-computed expectations checked by immediate assertions.
module tb_cpu_riscv;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Go  = 1'b0;
    logic [7:0]  SEG, AN;
    logic        halt, e_signal;
    logic [31:0] PC_Data, IR_Data, in_PC, LED_num, R1Data, R2Data, ALUData, rd_in;
    logic [31:0] Imm_value, Imm_shift_value;
    logic [4:0]  R1Addr, R2Addr, RD;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  segt [16];

    cpu_riscv #(.IMEM_WORDS(1024), .DMEM_WORDS(1024), .IMEM_FILE(""), .SCAN_DIV(2)) dut (
        .CLK(CLK), .RST(RST), .Go(Go), .SEG(SEG), .AN(AN), .halt(halt),
        .PC_Data(PC_Data), .IR_Data(IR_Data), .in_PC(in_PC), .LED_num(LED_num),
        .R1Addr(R1Addr), .R2Addr(R2Addr), .RD(RD), .R1Data(R1Data), .R2Data(R2Data),
        .ALUData(ALUData), .rd_in(rd_in), .Imm_value(Imm_value),
        .Imm_shift_value(Imm_shift_value), .e_signal(e_signal)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] o, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] o, input logic [4:0] rd);
        return {o[20], o[10:1], o[11], o[19:12], rd, 7'h6F};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) dut.imem[i] = '0;
    endtask

    task automatic put(input int unsigned addr, input logic [31:0] w);
        dut.imem[addr >> 2] = w;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(1);
        RST = 1'b0;
    endtask

    initial begin
        segt = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        @(negedge CLK);

        // Program A: print 0x123 via ecall a7=34
        clear_rom();
        put(32'h0, enc_i(12'h123, 5'd0, 3'd0, 5'd10, 7'h13));
        put(32'h4, enc_i(12'd34, 5'd0, 3'd0, 5'd17, 7'h13));
        put(32'h8, 32'h0000_0073);
        do_reset();
        check("rst_pc",   PC_Data, 32'h0);
        check("rst_halt", {31'b0, halt}, 32'h0);
        check("rst_led",  LED_num, 32'h0);
        check("rst_an",   {24'b0, AN}, 32'hFE);
        check("rst_seg",  {24'b0, SEG}, 32'hC0);
        step(1);
        check("a_ir1",  IR_Data, 32'h0220_0893);
        step(1);
        check("a_ecall_e", {31'b0, e_signal}, 32'h1);
        check("a_ecall_npc", in_PC, 32'hC);
        step(1);
        check("a_led",  LED_num, 32'h0000_0123);
        check("a_pc",   PC_Data, 32'hC);
        check("a_halt", {31'b0, halt}, 32'h0);

        // Display: LED=0x89ABCDEF, scan every 4 clocks
        clear_rom();
        put(32'h0, {20'h89ABD, 5'd10, 7'h37});
        put(32'h4, enc_i(12'hDEF, 5'd10, 3'd0, 5'd10, 7'h13));
        put(32'h8, enc_i(12'd34, 5'd0, 3'd0, 5'd17, 7'h13));
        put(32'hC, 32'h0000_0073);
        do_reset();
        check("lui_alu", ALUData, 32'h89AB_D000);
        step(4);
        check("d_led", LED_num, 32'h89AB_CDEF);
        for (int k = 4; k < 36; k++) begin
            int          dg;
            logic [31:0] lv;
            dg = (k / 4) % 8;
            lv = 32'h89AB_CDEF >> (4 * dg);
            check($sformatf("d_an_k%0d", k),  {24'b0, AN},  {24'b0, ~(8'h01 << dg)});
            check($sformatf("d_seg_k%0d", k), {24'b0, SEG}, {24'b0, segt[lv[3:0]]});
            step(1);
        end
        do_reset();
        check("d_rst_an",  {24'b0, AN},  32'hFE);
        check("d_rst_seg", {24'b0, SEG}, 32'hC0);
        check("d_rst_led", LED_num, 32'h0);

        // Program B: arithmetic and memory
        clear_rom();
        put(32'h00, enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
        put(32'h04, enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13));
        put(32'h08, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));
        put(32'h0C, enc_s(12'd8, 5'd3, 5'd0));
        put(32'h10, enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'h03));
        put(32'h14, enc_r(7'h00, 5'd0, 5'd4, 3'd0, 5'd5));
        put(32'h18, enc_i(12'h401, 5'd2, 3'b101, 5'd7, 7'h13));
        put(32'h1C, enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd8));
        put(32'h20, enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13));
        put(32'h24, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6));
        do_reset();
        step(2);
        check("b_sub_r2", R2Data, 32'hFFFF_FFFD);
        check("b_sub_alu", ALUData, 32'h8);
        step(1);
        check("b_sw_imm", Imm_value, 32'h8);
        check("b_sw_data", R2Data, 32'h8);
        step(1);
        check("b_lw_alu", ALUData, 32'h8);
        check("b_lw_rdin", rd_in, 32'h8);
        step(1);
        check("b_x4", R1Data, 32'h8);
        step(1);
        check("b_srai", ALUData, 32'hFFFF_FFFE);
        step(1);
        check("b_sltu", ALUData, 32'h1);
        step(2);
        check("b_x0", R1Data, 32'h0);

        // Program C: branches
        clear_rom();
        put(32'h00, enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13));
        put(32'h04, enc_b(13'd8, 5'd0, 5'd1, 3'b001));
        put(32'h08, enc_i(12'd99, 5'd0, 3'd0, 5'd9, 7'h13));
        put(32'h0C, enc_b(13'd8, 5'd1, 5'd1, 3'b000));
        put(32'h10, enc_i(12'd99, 5'd0, 3'd0, 5'd9, 7'h13));
        put(32'h14, enc_b(13'd8, 5'd0, 5'd1, 3'b000));
        put(32'h18, enc_b(13'h1FE8, 5'd0, 5'd1, 3'b001));
        do_reset();
        step(1);
        check("c_bne_imm",  Imm_value, 32'h4);
        check("c_bne_sh",   Imm_shift_value, 32'h8);
        check("c_bne_npc",  in_PC, 32'hC);
        step(1);
        check("c_bne_pc",   PC_Data, 32'hC);
        check("c_beq_npc",  in_PC, 32'h14);
        step(1);
        check("c_nt_npc",   in_PC, 32'h18);
        step(1);
        check("c_back_imm", Imm_value, 32'hFFFF_FFF4);
        check("c_back_sh",  Imm_shift_value, 32'hFFFF_FFE8);
        step(1);
        check("c_back_pc",  PC_Data, 32'h0);

        // Program D: halt, resume, reset beats Go
        clear_rom();
        put(32'h0, enc_i(12'd10, 5'd0, 3'd0, 5'd17, 7'h13));
        put(32'h4, 32'h0000_0073);
        put(32'h8, 32'h0000_0073);
        do_reset();
        step(1);
        check("h_e",   {31'b0, e_signal}, 32'h1);
        check("h_npc", in_PC, 32'h4);
        step(1);
        check("h_halt", {31'b0, halt}, 32'h1);
        step(20);
        check("h_pc_frozen", PC_Data, 32'h4);
        check("h_still", {31'b0, halt}, 32'h1);
        check("h_npc_hold", in_PC, 32'h4);
        Go = 1'b1;
        step(1);
        Go = 1'b0;
        check("h_go_halt", {31'b0, halt}, 32'h0);
        check("h_go_pc", PC_Data, 32'h8);
        step(1);
        check("h_rehalt", {31'b0, halt}, 32'h1);
        RST = 1'b1;
        Go  = 1'b1;
        step(1);
        RST = 1'b0;
        Go  = 1'b0;
        check("h_rstgo_pc", PC_Data, 32'h0);
        check("h_rstgo_halt", {31'b0, halt}, 32'h0);

        // ecall a7=36: counter readout if built in, otherwise halts
        clear_rom();
        put(32'h0, enc_i(12'd36, 5'd0, 3'd0, 5'd17, 7'h13));
        put(32'h4, 32'h0000_0073);
        do_reset();
        step(2);
`ifdef CPU_RISCV_INSTCNT_EN
        check("cnt_halt", {31'b0, halt}, 32'h0);
        check("cnt_pc",   PC_Data, 32'h8);
        check("cnt_led",  LED_num, 32'h1);
`else
        check("cnt_halt", {31'b0, halt}, 32'h1);
        check("cnt_pc",   PC_Data, 32'h4);
`endif

        // Program E: jal / jalr / auipc
        clear_rom();
        put(32'h20, enc_j(21'd16, 5'd1));
        put(32'h24, enc_i(12'd9, 5'd1, 3'd0, 5'd5, 7'h67));
        put(32'h2C, {20'h00001, 5'd6, 7'h17});
        put(32'h30, enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'h67));
        do_reset();
        step(8);
        check("j_pc",    PC_Data, 32'h20);
        check("j_imm",   Imm_value, 32'h8);
        check("j_sh",    Imm_shift_value, 32'h10);
        check("j_rdin",  rd_in, 32'h24);
        check("j_npc",   in_PC, 32'h30);
        step(1);
        check("jr_x1",   R1Data, 32'h24);
        check("jr_npc",  in_PC, 32'h24);
        step(1);
        check("jr2_npc", in_PC, 32'h2C);
        check("jr2_rdin", rd_in, 32'h28);
        step(1);
        check("auipc",   ALUData, 32'h102C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
